// File: rtl/bsg_kda_arbiter_if.sv
// Bundle of the requester, response and kda-core handshakes around bsg_kda_arbiter.
//   slave  : the arbiter side (drives req_ready_o, resp_*_o, core_v_o/core_data_o/core_yumi_o)
//   master : the environment side (requesters plus the kda core)
interface bsg_kda_arbiter_if #(
    parameter int unsigned num_req_p = 4,
    parameter int unsigned width_p   = 64
);
    logic [num_req_p-1:0]         req_v_i;
    logic [num_req_p*width_p-1:0] req_data_i;
    logic [num_req_p-1:0]         req_ready_o;
    logic [num_req_p-1:0]         resp_v_o;
    logic [width_p-1:0]           resp_data_o;
    logic                         resp_err_o;
    logic [num_req_p-1:0]         resp_yumi_i;
    logic                         core_v_o;
    logic [width_p-1:0]           core_data_o;
    logic                         core_ready_i;
    logic                         core_v_i;
    logic [width_p-1:0]           core_data_i;
    logic                         core_yumi_o;

    modport slave (
        input  req_v_i, req_data_i, resp_yumi_i, core_ready_i, core_v_i, core_data_i,
        output req_ready_o, resp_v_o, resp_data_o, resp_err_o, core_v_o, core_data_o, core_yumi_o
    );

    modport master (
        output req_v_i, req_data_i, resp_yumi_i, core_ready_i, core_v_i, core_data_i,
        input  req_ready_o, resp_v_o, resp_data_o, resp_err_o, core_v_o, core_data_o, core_yumi_o
    );
endinterface

// File: rtl/bsg_kda_arbiter.sv
// Round-robin arbiter sharing one kda core among num_req_p requesters, one job in flight.
// Ports:
//   clk_i   : clock, all state on rising edge
//   reset_i : asynchronous active-high reset
//   bus     : bsg_kda_arbiter_if.slave -- requester jobs/results and kda core handshakes
// Optional feature: define BSG_KDA_ARBITER_WATCHDOG_EN to bound the core wait by timeout_p
// cycles; on expiry the owner gets an all-ones error result and the late core result is
// later swallowed before any new grant.
module bsg_kda_arbiter #(
    parameter int unsigned num_req_p = 4,
    parameter int unsigned width_p   = 64,
    parameter int unsigned timeout_p = 1024
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bsg_kda_arbiter_if.slave bus
);
    localparam int unsigned id_width_lp = $clog2(num_req_p);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_e;

    state_e                 state;
    logic [id_width_lp-1:0] rr_ptr;
    logic [id_width_lp-1:0] owner;
    logic [width_p-1:0]     payload;
    logic [width_p-1:0]     result;
    logic                   stale;

`ifdef BSG_KDA_ARBITER_WATCHDOG_EN
    localparam int unsigned cnt_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    logic [cnt_width_lp-1:0] wait_cnt;
    logic                    err;
`else
    logic unused_timeout;
    assign unused_timeout = 1'(timeout_p);
    assign stale          = 1'b0;
`endif

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    logic                   grant_v;
    logic [id_width_lp-1:0] grant_id;
    logic [id_width_lp-1:0] probe_id;
    logic [31:0]            probe_sum;

    always_comb begin
        grant_v   = 1'b0;
        grant_id  = '0;
        probe_id  = '0;
        probe_sum = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            probe_sum = 32'(rr_ptr) + k;
            probe_id  = id_width_lp'((probe_sum >= num_req_p) ? probe_sum - num_req_p : probe_sum);
            if (!grant_v && bus.req_v_i[probe_id]) begin
                grant_v  = 1'b1;
                grant_id = probe_id;
            end
        end
    end

    // A stale core result must drain before another job may be granted.
    logic accept;
    assign accept = (state == IDLE) && grant_v && !stale;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            payload <= '0;
            result  <= '0;
`ifdef BSG_KDA_ARBITER_WATCHDOG_EN
            wait_cnt <= '0;
            err      <= 1'b0;
            stale    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner   <= grant_id;
                        payload <= bus.req_data_i[32'(grant_id) * width_p +: width_p];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.core_ready_i) begin
                        state <= WAIT;
`ifdef BSG_KDA_ARBITER_WATCHDOG_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    // A result arriving on the timeout cycle takes priority over the error.
                    if (bus.core_v_i) begin
                        result <= bus.core_data_i;
                        state  <= DELIVER;
`ifdef BSG_KDA_ARBITER_WATCHDOG_EN
                        err    <= 1'b0;
                    end else if (wait_cnt == cnt_width_lp'(timeout_p - 1)) begin
                        result <= '1;
                        err    <= 1'b1;
                        stale  <= 1'b1;
                        state  <= DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                DELIVER: begin
                    if (bus.resp_yumi_i[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= (owner == id_width_lp'(num_req_p - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef BSG_KDA_ARBITER_WATCHDOG_EN
            // The abandoned job's result is consumed and dropped.
            if (stale && bus.core_v_i) begin
                stale <= 1'b0;
            end
`endif
        end
    end

    assign bus.req_ready_o = accept ? (num_req_p'(1) << grant_id) : '0;
    assign bus.core_v_o    = (state == ISSUE);
    assign bus.core_data_o = payload;
    assign bus.core_yumi_o = bus.core_v_i && ((state == WAIT) || stale);
    assign bus.resp_v_o    = (state == DELIVER) ? (num_req_p'(1) << owner) : '0;
    assign bus.resp_data_o = result;
`ifdef BSG_KDA_ARBITER_WATCHDOG_EN
    assign bus.resp_err_o  = (state == DELIVER) && err;
`else
    assign bus.resp_err_o  = 1'b0;
`endif

endmodule

// File: doc/bsg_kda_arbiter.md
BSG_KDA_ARBITER -- requirements
Module: bsg_kda_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 4: number of requesters sharing one kda core; 2..16.
REQ-002 SHALL have parameter width_p, default 64: job/result data width.
REQ-003 SHALL have parameter timeout_p, default 1024: core watchdog limit in cycles; used only under REQ-027.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_i  input  1  reset, asynchronous, active-high.
REQ-006 req_v_i  input  num_req_p  per-requester job valid.
REQ-007 req_data_i  input  num_req_p*width_p  job payloads; requester i occupies bits [i*width_p +: width_p].
REQ-008 req_ready_o  output  num_req_p  one-hot job accept.
REQ-009 resp_v_o  output  num_req_p  one-hot result valid, owner only.
REQ-010 resp_data_o  output  width_p  result data, shared by all requesters.
REQ-011 resp_err_o  output  1  result is a watchdog error, not core data.
REQ-012 resp_yumi_i  input  num_req_p  per-requester result consume.
REQ-013 core_v_o / core_data_o  output  1 / width_p  job to kda core.
REQ-014 core_ready_i  input  1  kda core accepts job.
REQ-015 core_v_i / core_data_i  input  1 / width_p  result from kda core.
REQ-016 core_yumi_o  output  1  consume kda core result.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, DELIVER; exactly one job outstanding at any time.
- IDLE: grant = first i with req_v_i[i]=1, searching from rr_ptr upward with wrap; req_ready_o[grant]=1 combinationally, all other bits 0; on accept, latch payload and owner id, go to ISSUE; no req_v_i -> remain in IDLE with req_ready_o all 0.
- ISSUE: core_v_o=1, core_data_o=latched payload; core_ready_i=1 -> WAIT; otherwise hold, with payload stable.
- WAIT: core_yumi_o=core_v_i; core_v_i=1 -> latch core_data_i, resp_err_o=0 -> DELIVER.
- DELIVER: resp_v_o[owner]=1, resp_data_o=latched result; resp_yumi_i[owner]=1 -> IDLE, rr_ptr<=(owner+1) mod num_req_p.
REQ-018 Minimum latency: accept in cycle 0, core_v_o in cycle 1; result 1 cycle after core_v_i; IDLE reentered cycle after yumi.
REQ-019 resp_yumi_i bits of non-owners, and any resp_yumi_i outside DELIVER, SHALL be ignored.
REQ-020 core_v_i outside WAIT SHALL NOT be consumed (core_yumi_o=0), except per REQ-027.
REQ-021 req_ready_o SHALL be 0 in every state other than IDLE; no new grant while a job is outstanding.
REQ-022 rr_ptr SHALL be updated only on DELIVER completion; wrap from num_req_p-1 to 0.
REQ-023 Requester dropping req_v_i before grant SHALL lose nothing; granted payload is the value present in the accept cycle.

Reset
REQ-024 Reset SHALL force IDLE, rr_ptr=0, clear latched owner, payload, result, and watchdog state; reset mid-job abandons the job with no response.
REQ-025 During and after reset, until the next accept: req_ready_o=0 when no req_v_i, resp_v_o=0, resp_err_o=0, core_v_o=0, core_yumi_o=0, core_data_o=0, resp_data_o=0.

Configuration
REQ-026 Macro BSG_KDA_ARBITER_WATCHDOG_EN SHALL select watchdog logic.
REQ-027 Defined: WAIT counts cycles from entry; if the count reaches timeout_p without core_v_i, go to DELIVER with resp_data_o all ones, resp_err_o=1, and set stale flag. While stale flag is set: core_yumi_o=core_v_i in any state, the first consumed result clears the flag and is discarded, and IDLE grants nothing. core_v_i on the same cycle as the timeout SHALL win: normal result, no error.
REQ-028 Undefined: no counter, no stale flag, resp_err_o tied 0, WAIT unbounded.

Verification
REQ-029 Reset, then req_v_i=4'b0001 with data 0x1; core returns 0xAB after 3 cycles -> core_v_o at cycle 1, resp_v_o=4'b0001, resp_data_o=0xAB, rr_ptr=1.
REQ-030 All four requesters valid continuously -> grant order 0,1,2,3,0; each requester receives only its own result.
REQ-031 Owner 2 in DELIVER, resp_yumi_i=4'b0001 held for 5 cycles -> remains in DELIVER; resp_yumi_i=4'b0100 -> returns to IDLE.
REQ-032 core_ready_i held 0 for 10 cycles -> core_v_o and core_data_o stable throughout; req_ready_o=0 throughout.
REQ-033 Macro defined, timeout_p=8, core silent -> after 8 WAIT cycles, resp_err_o=1 and data 0xFFFF_FFFF_FFFF_FFFF; core result arriving late is consumed and discarded, and the next grant occurs only afterwards.
REQ-034 reset_i asserted while in WAIT -> all outputs return to their REQ-025 values immediately (asynchronously); the next job is serviced normally.
